layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Parametrised layer-instruction sequencer for the YOLOv5 accelerator top level. Fetches opcodes from
//  sync instruction ROM, dispatches each to one of N_ENG engines (conv, pool, concat, shortcut,
//  upsample, ...) via start/fin handshake, supports one hardware loop level and flags illegal opcodes.
// PARAMETERS
//  INSTR_W  16  instruction width; opcode = instr[OP_W-1:0], operand = instr[INSTR_W-1:OP_W]
//  OP_W     4   opcode field width
//  ADDR_W   10  instruction address width
//  N_ENG    5   engine count; opcodes 1..N_ENG map to engine index opcode-1 (N_ENG <= 2**OP_W-4)
//  WDOG_W   20  watchdog counter width (used only with LAYER_SEQ_WDOG_EN)
// PORTS
//  clk        in   1        clock
//  reset_n    in   1        asynchronous, active-low reset
//  start      in   1        level-sampled in IDLE: begin program at address 0
//  abort      in   1        synchronous abort, any state -> IDLE
//  instr_rd   out  1        ROM read enable; instr valid exactly 1 cycle later
//  instr_adr  out  ADDR_W   ROM address (program counter)
//  instr      in   INSTR_W  ROM data
//  eng_start  out  N_ENG    one-hot, 1-cycle start pulse to selected engine
//  eng_instr  out  INSTR_W  registered copy of dispatched instruction, held until next dispatch
//  eng_fin    in   N_ENG    per-engine completion pulse
//  busy       out  1        high in any state except IDLE/ERR
//  done       out  1        1-cycle pulse on END execution
//  err        out  1        sticky error flag, cleared by start or reset
//  state      out  3        FSM state code for debug
// BEHAVIOUR
//  Reset: state=IDLE(0), instr_adr=0, instr_rd=0, eng_start=0, eng_instr=0, done=0, err=0, loop regs=0.
//  States: IDLE(0) FETCH(1) DECODE(2) WAIT(3) ERR(7); all outputs registered.
//  IDLE: start=1 -> FETCH, pc=0, err cleared. start while busy ignored.
//  FETCH: instr_rd=1 for one cycle at instr_adr=pc -> DECODE.
//  DECODE (instr valid), by opcode:
//   0 NOP: pc+1 -> FETCH.
//   1..N_ENG: eng_start[op-1]=1 next cycle, eng_instr<=instr -> WAIT.
//   0xD LOOP: loop_adr<=pc+1, loop_cnt<=operand, pc+1 -> FETCH (nested LOOP overwrites).
//   0xE ENDLOOP: loop_cnt!=0 -> loop_cnt-1, pc<=loop_adr; else pc+1; -> FETCH.
//     Body therefore runs operand+1 times; operand=0 runs once.
//   0xF END: done pulse 1 cycle, pc<=0 -> IDLE.
//   other (incl. engine opcodes > N_ENG): err<=1 -> ERR.
//  WAIT: only eng_fin[active] advances (pc+1 -> FETCH); fin from other engines ignored.
//   fin coinciding with the eng_start cycle is ignored (sampled from cycle after start).
//  Dispatch-to-next-fetch latency: fin cycle +1 = FETCH, +2 = DECODE.
//  pc wrap: increment from 2**ADDR_W-1 -> err<=1, ERR (no silent wrap).
//  ERR: busy=0, err=1; holds until start (-> FETCH at 0, err cleared) or reset.
//  abort: highest priority after reset; -> IDLE, pc=0, eng_start=0, loop_cnt=0; err unchanged; no done.
//  Async reset mid-operation: immediate return to reset values; engines must be reset alongside.
// CONFIGURATION
//  LAYER_SEQ_WDOG_EN defined: WDOG_W counter cleared on entering WAIT, +1 per WAIT cycle; reaching
//   all-ones before eng_fin -> err<=1, ERR. Undefined: no counter, WAIT waits indefinitely.
// TESTING
//  ROM {op1,op2,0xF}, fin 3 cycles after each start -> eng_start[0] then [1] pulses, done once, adr 0,1,2.
//  ROM {0xD w/ operand 2, op3, 0xE, 0xF} -> eng_start[2] pulsed exactly 3 times, then done.
//  op5 dispatched, eng_fin[0] pulsed during WAIT -> stays in WAIT until eng_fin[4].
//  ROM {0x9} with N_ENG=5 -> err=1, state=ERR, busy=0; then start -> err=0, fetch at adr 0.
//  abort in WAIT -> IDLE next cycle, no done; reset_n low mid-WAIT -> all outputs at reset values at once.
//  With LAYER_SEQ_WDOG_EN, WDOG_W=4, no fin -> err=1 after 15 WAIT cycles.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Instruction-ROM read port and engine start/fin dispatch bus of layer_sequencer.
interface layer_sequencer_if #(
   parameter int INSTR_W = 16,
   parameter int ADDR_W  = 10,
   parameter int N_ENG   = 5
);
   logic               instr_rd;
   logic [ADDR_W-1:0]  instr_adr;
   logic [INSTR_W-1:0] instr;
   logic [N_ENG-1:0]   eng_start;
   logic [INSTR_W-1:0] eng_instr;
   logic [N_ENG-1:0]   eng_fin;

   modport master (output instr_rd, instr_adr, eng_start, eng_instr,
                   input  instr, eng_fin);
   modport slave  (input  instr_rd, instr_adr, eng_start, eng_instr,
                   output instr, eng_fin);
endinterface

// File: rtl/layer_sequencer.sv
// Layer-instruction sequencer: ROM fetch, engine dispatch, one loop level, illegal-opcode trap.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_WDOG_EN.
module layer_sequencer #(
   parameter int INSTR_W = 16,
   parameter int OP_W    = 4,
   parameter int ADDR_W  = 10,
   parameter int N_ENG   = 5,
   parameter int WDOG_W  = 20
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   layer_sequencer_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        state
);
   localparam int OPD_W = INSTR_W - OP_W;
   localparam int IDX_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
   localparam logic [OP_W-1:0] OP_NOP     = '0;
   localparam logic [OP_W-1:0] OP_LOOP    = OP_W'(13);
   localparam logic [OP_W-1:0] OP_ENDL    = OP_W'(14);
   localparam logic [OP_W-1:0] OP_END     = OP_W'(15);
   localparam logic [OP_W-1:0] OP_ENG_MAX = OP_W'(N_ENG);

   if (N_ENG > 2**OP_W - 4) begin : g_bad_neng
      $error("N_ENG collides with control opcodes");
   end
   if (WDOG_W < 2) begin : g_bad_wdog
      $error("WDOG_W too small");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_WAIT   = 3'd3,
      S_ERR    = 3'd7
   } state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_instr_rd;
   logic [N_ENG-1:0]   r_eng_start;
   logic [INSTR_W-1:0] r_eng_instr;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [ADDR_W-1:0]  r_loop_adr;
   logic [OPD_W-1:0]   r_loop_cnt;
   logic [IDX_W-1:0]   r_active;
`ifdef LAYER_SEQ_WDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
   logic [WDOG_W-1:0]  r_wdog;
`endif

   logic [OP_W-1:0]    w_op;
   logic [OPD_W-1:0]   w_opd;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic               w_pc_last;
   logic               w_is_eng;
   logic               w_fin;
   logic               w_step;

   assign w_op      = bus.instr[OP_W-1:0];
   assign w_opd     = bus.instr[INSTR_W-1:OP_W];
   assign w_pc_inc  = r_pc + 1'b1;
   assign w_pc_last = &r_pc;
   assign w_is_eng  = (w_op != OP_NOP) && (w_op <= OP_ENG_MAX);
   // A fin landing in the same cycle as the start pulse belongs to a previous job.
   assign w_fin     = bus.eng_fin[r_active] && (r_eng_start == '0);
   // Every sequential advance (pc+1) funnels through here so the wrap trap lives in one place.
   assign w_step    = ((r_state == S_DECODE) &&
                       ((w_op == OP_NOP) || (w_op == OP_LOOP) ||
                        ((w_op == OP_ENDL) && (r_loop_cnt == '0)))) ||
                      ((r_state == S_WAIT) && w_fin);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_instr_rd  <= 1'b0;
         r_eng_start <= '0;
         r_eng_instr <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_loop_adr  <= '0;
         r_loop_cnt  <= '0;
         r_active    <= '0;
`ifdef LAYER_SEQ_WDOG_EN
         r_wdog      <= '0;
`endif
      end else begin
         r_instr_rd  <= 1'b0;
         r_eng_start <= '0;
         r_done      <= 1'b0;
         if (abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_pc       <= '0;
            r_loop_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_ERR: begin
                  if (start) begin
                     r_state    <= S_FETCH;
                     r_busy     <= 1'b1;
                     r_instr_rd <= 1'b1;
                     r_pc       <= '0;
                     r_err      <= 1'b0;
                  end
               end
               S_FETCH: r_state <= S_DECODE;
               S_DECODE: begin
                  if (w_op == OP_LOOP) begin
                     r_loop_adr <= w_pc_inc;
                     r_loop_cnt <= w_opd;
                  end else if (w_op == OP_ENDL) begin
                     if (r_loop_cnt != '0) begin
                        r_loop_cnt <= r_loop_cnt - 1'b1;
                        r_pc       <= r_loop_adr;
                        r_state    <= S_FETCH;
                        r_instr_rd <= 1'b1;
                     end
                  end else if (w_op == OP_END) begin
                     r_done  <= 1'b1;
                     r_pc    <= '0;
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else if (w_is_eng) begin
                     r_eng_start <= N_ENG'(1) << (w_op - 1'b1);
                     r_eng_instr <= bus.instr;
                     r_active    <= IDX_W'(w_op - 1'b1);
                     r_state     <= S_WAIT;
`ifdef LAYER_SEQ_WDOG_EN
                     r_wdog      <= '0;
`endif
                  end else if (w_op != OP_NOP) begin
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                     r_busy  <= 1'b0;
                  end
               end
               S_WAIT: begin
`ifdef LAYER_SEQ_WDOG_EN
                  if (!w_fin) begin
                     r_wdog <= r_wdog + 1'b1;
                     if (r_wdog == WDOG_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                     end
                  end
`endif
               end
               default: begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
                  r_busy  <= 1'b0;
               end
            endcase
            if (w_step) begin
               if (w_pc_last) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
                  r_busy  <= 1'b0;
               end else begin
                  r_pc       <= w_pc_inc;
                  r_state    <= S_FETCH;
                  r_instr_rd <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.instr_rd  = r_instr_rd;
   assign bus.instr_adr = r_pc;
   assign bus.eng_start = r_eng_start;
   assign bus.eng_instr = r_eng_instr;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign state         = r_state;
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboarded bench for layer_sequencer: directed handshake cases plus random programs vs. an ISA-level model.
`timescale 1ns/1ps
module tb_layer_sequencer;
   localparam int INSTR_W = 16;
   localparam int OP_W    = 4;
   localparam int ADDR_W  = 10;
   localparam int N_ENG   = 5;
   localparam int K_DISP  = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERR   = 2;

   typedef struct {
      int                 kind;
      logic [N_ENG-1:0]   oh;
      logic [INSTR_W-1:0] ins;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy, done, err;
   logic [2:0] state;

   layer_sequencer_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .N_ENG(N_ENG)) bus();

   layer_sequencer #(.INSTR_W(INSTR_W), .OP_W(OP_W), .ADDR_W(ADDR_W), .N_ENG(N_ENG), .WDOG_W(20)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .bus(bus.master),
      .busy(busy), .done(done), .err(err), .state(state));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   ev_t         exp_q[$];
   int          adr_log[$];
   logic [15:0] rom [32];
   int          fin_dly = 3;
   bit          auto_fin = 1'b1;
   int          start_cnt [N_ENG];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ROM and engine responders: ROM returns data one cycle after instr_rd, engines fin fin_dly cycles after start.
   initial begin
      bit pend;
      int cnt, eng;
      pend = 1'b0; cnt = 0; eng = 0;
      bus.instr = '0; bus.eng_fin = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pend = 1'b0;
            if (auto_fin) bus.eng_fin = '0;
            continue;
         end
         if (bus.instr_rd) begin
            bus.instr = rom[bus.instr_adr[4:0]];
            adr_log.push_back(int'(bus.instr_adr));
         end
         if (auto_fin) begin
            bus.eng_fin = '0;
            if (pend) begin
               if (cnt == 0) begin bus.eng_fin[eng] = 1'b1; pend = 1'b0; end
               else cnt--;
            end
            if (bus.eng_start != '0) begin
               pend = 1'b1; cnt = fin_dly - 1;
               for (int k = 0; k < N_ENG; k++) if (bus.eng_start[k]) eng = k;
            end
         end
      end
   end

   // Monitor: every observable event pops the scoreboard.
   initial begin
      logic prev_err;
      ev_t  e;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin prev_err = 1'b0; continue; end
         if (bus.eng_start != '0) begin
            for (int k = 0; k < N_ENG; k++) if (bus.eng_start[k]) start_cnt[k]++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_dispatch actual=%b expected=none", bus.eng_start);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_disp", 32'(K_DISP), 32'(e.kind));
               chk("eng_start", 32'(bus.eng_start), 32'(e.oh));
               chk("eng_instr", 32'(bus.eng_instr), 32'(e.ins));
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_done", 32'(K_DONE), 32'(e.kind));
            end
         end
         if (err && !prev_err) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_err actual=1 expected=0");
            end else begin
               e = exp_q.pop_front();
               chk("event_kind_err", 32'(K_ERR), 32'(e.kind));
            end
         end
         prev_err = err;
      end
   end

   // Reference: executes the ROM as a program, listing dispatches then DONE or ERR.
   task automatic build_exp(output bit is_err);
      int pc, lcnt, ladr;
      logic [15:0] w;
      logic [N_ENG-1:0] oh;
      pc = 0; lcnt = 0; ladr = 0; is_err = 1'b0;
      for (int s = 0; s < 500; s++) begin
         w = rom[pc];
         if (int'(w[3:0]) == 0) pc++;
         else if (int'(w[3:0]) <= N_ENG) begin
            oh = '0; oh[int'(w[3:0]) - 1] = 1'b1;
            exp_q.push_back('{kind: K_DISP, oh: oh, ins: w});
            pc++;
         end else if (w[3:0] == 4'hD) begin
            ladr = pc + 1; lcnt = int'(w[15:4]); pc++;
         end else if (w[3:0] == 4'hE) begin
            if (lcnt != 0) begin lcnt--; pc = ladr; end
            else pc++;
         end else if (w[3:0] == 4'hF) begin
            exp_q.push_back('{kind: K_DONE, oh: '0, ins: '0});
            return;
         end else begin
            exp_q.push_back('{kind: K_ERR, oh: '0, ins: '0});
            is_err = 1'b1;
            return;
         end
      end
   endtask

   function automatic logic [15:0] rand_op();
      logic [3:0] op;
      op = 4'($urandom_range(0, N_ENG));
      return {12'($urandom), op};
   endfunction

   task automatic gen_prog();
      int n, m;
      n = 0;
      for (int i = 0; i < 32; i++) rom[i] = 16'h000F;
      m = $urandom_range(0, 3);
      for (int i = 0; i < m; i++) begin rom[n] = rand_op(); n = n + 1; end
      if ($urandom_range(0, 1) == 1) begin
         rom[n] = {12'($urandom_range(0, 3)), 4'hD}; n = n + 1;
         m = $urandom_range(1, 3);
         for (int i = 0; i < m; i++) begin rom[n] = rand_op(); n = n + 1; end
         rom[n] = {12'($urandom), 4'hE}; n = n + 1;
      end
      m = $urandom_range(0, 3);
      for (int i = 0; i < m; i++) begin rom[n] = rand_op(); n = n + 1; end
      if ($urandom_range(0, 5) == 0) rom[n] = {12'($urandom), 4'($urandom_range(6, 12))};
      else rom[n] = {12'($urandom), 4'hF};
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = 16'h000F;
   endtask

   task automatic start_prog();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic finish_prog(input bit exp_err);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (done || state == 3'd7) seen = 1'b1;
      end
      chk("prog_terminates", 32'(seen), 32'd1);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("end_state", 32'(state), exp_err ? 32'd7 : 32'd0);
      chk("end_err", 32'(err), 32'(exp_err));
      chk("end_busy", 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   task automatic wait_start();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (bus.eng_start != '0) seen = 1'b1;
      end
      chk("dispatch_seen", 32'(seen), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_instr_rd"}, 32'(bus.instr_rd), 32'd0);
      chk({tag, "_instr_adr"}, 32'(bus.instr_adr), 32'd0);
      chk({tag, "_eng_start"}, 32'(bus.eng_start), 32'd0);
      chk({tag, "_eng_instr"}, 32'(bus.eng_instr), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      bit e;
      for (int k = 0; k < N_ENG; k++) start_cnt[k] = 0;
      clear_rom();
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // {op1, op2, END}: two dispatches, fetch addresses 0,1,2
      clear_rom();
      rom[0] = {12'h0A5, 4'h1}; rom[1] = {12'h123, 4'h2}; rom[2] = 16'h000F;
      fin_dly = 3; adr_log.delete();
      build_exp(e); start_prog(); finish_prog(e);
      chk("adr_log_len", 32'(adr_log.size()), 32'd3);
      for (int i = 0; i < 3 && i < adr_log.size(); i++) chk("adr_log", 32'(adr_log[i]), 32'(i));

      // LOOP 2 around op3: engine 2 started three times
      clear_rom();
      rom[0] = {12'd2, 4'hD}; rom[1] = {12'h055, 4'h3}; rom[2] = 16'h000E; rom[3] = 16'h000F;
      for (int k = 0; k < N_ENG; k++) start_cnt[k] = 0;
      build_exp(e); start_prog(); finish_prog(e);
      chk("loop_start_cnt", 32'(start_cnt[2]), 32'd3);

      // op5 in WAIT: fin coincident with start and fin from engine 0 both ignored
      clear_rom();
      rom[0] = 16'h0AB5; rom[1] = 16'h000F;
      auto_fin = 1'b0;
      exp_q.push_back('{kind: K_DISP, oh: 5'b10000, ins: 16'h0AB5});
      exp_q.push_back('{kind: K_DONE, oh: '0, ins: '0});
      start_prog(); wait_start();
      bus.eng_fin = 5'b10000;
      @(negedge clk); bus.eng_fin = 5'b00001;
      chk("coincident_fin_ignored", 32'(state), 32'd3);
      @(negedge clk); bus.eng_fin = '0;
      chk("other_fin_ignored", 32'(state), 32'd3);
      repeat (3) @(negedge clk);
      chk("wait_holds", 32'(state), 32'd3);
      bus.eng_fin = 5'b10000;
      @(negedge clk); bus.eng_fin = '0;
      chk("fin_to_fetch", 32'(state), 32'd1);
      chk("fin_to_fetch_rd", 32'(bus.instr_rd), 32'd1);
      @(negedge clk);
      chk("fin_to_decode", 32'(state), 32'd2);
      finish_prog(1'b0);
      auto_fin = 1'b1;

      // illegal opcode 9, abort keeps err, restart clears it
      clear_rom();
      rom[0] = 16'h0009;
      build_exp(e); start_prog(); finish_prog(e);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_in_err_state", 32'(state), 32'd0);
      chk("abort_keeps_err", 32'(err), 32'd1);
      clear_rom();
      rom[0] = 16'h0101; rom[1] = 16'h000F;
      build_exp(e); start_prog();
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_rd", 32'(bus.instr_rd), 32'd1);
      chk("restart_adr", 32'(bus.instr_adr), 32'd0);
      chk("restart_err", 32'(err), 32'd0);
      finish_prog(e);

      // abort in WAIT: back to IDLE, no done
      clear_rom();
      rom[0] = 16'h0012; rom[1] = 16'h000F;
      auto_fin = 1'b0;
      exp_q.push_back('{kind: K_DISP, oh: 5'b00010, ins: 16'h0012});
      start_prog(); wait_start();
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_adr", 32'(bus.instr_adr), 32'd0);
      repeat (5) @(negedge clk);
      chk("abort_stays_idle", 32'(state), 32'd0);
      chk("abort_scoreboard", 32'(exp_q.size()), 32'd0);

      // async reset mid-WAIT, with pc=1 and a live eng_instr
      clear_rom();
      rom[0] = 16'h0000; rom[1] = 16'h0033; rom[2] = 16'h000F;
      exp_q.push_back('{kind: K_DISP, oh: 5'b00100, ins: 16'h0033});
      start_prog(); wait_start();
      @(negedge clk); #1 reset_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      @(negedge clk); reset_n = 1'b1;
      chk("reset_scoreboard", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      auto_fin = 1'b1;

      // random programs
      for (int t = 0; t < 25; t++) begin
         gen_prog();
         fin_dly = $urandom_range(1, 4);
         build_exp(e); start_prog(); finish_prog(e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
